// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_pkg
// Description : Shared encodings for the two-master memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic GNT_M1 = 1'b0;
    localparam logic GNT_M2 = 1'b1;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_if
// Description : Master-side request/response buses plus memory port.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic              HTRANS_1;
    logic [ADDR_W-1:0] HADDR_1;
    logic              HWRITE_1;
    logic [DATA_W-1:0] HWDATA_1;
    logic [DATA_W-1:0] HRDATA_1;
    logic              HREADY_1;
    logic              HERR_1;

    logic              HTRANS_2;
    logic [ADDR_W-1:0] HADDR_2;
    logic              HWRITE_2;
    logic [DATA_W-1:0] HWDATA_2;
    logic [DATA_W-1:0] HRDATA_2;
    logic              HREADY_2;
    logic              HERR_2;

    logic              PSEL;
    logic [ADDR_W-1:0] PADDR;
    logic              PWRITE;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;

    logic              stall;
    logic              grant;

    // The master side is the surrounding system: both requesters and the memory.
    modport master (
        output HTRANS_1, HADDR_1, HWRITE_1, HWDATA_1,
        input  HRDATA_1, HREADY_1, HERR_1,
        output HTRANS_2, HADDR_2, HWRITE_2, HWDATA_2,
        input  HRDATA_2, HREADY_2, HERR_2,
        input  PSEL, PADDR, PWRITE, PWDATA,
        output PRDATA, PREADY,
        input  stall, grant
    );

    modport slave (
        input  HTRANS_1, HADDR_1, HWRITE_1, HWDATA_1,
        output HRDATA_1, HREADY_1, HERR_1,
        input  HTRANS_2, HADDR_2, HWRITE_2, HWDATA_2,
        output HRDATA_2, HREADY_2, HERR_2,
        output PSEL, PADDR, PWRITE, PWDATA,
        input  PRDATA, PREADY,
        output stall, grant
    );

endinterface
`default_nettype wire

// File: rtl/mem_arb_pick.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pick
// Description : Combinational winner selection; a tie goes to the master not
//               granted last.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arb_pick
    import mem_arbiter_pkg::*;
(
    input  wire  i_req_1,
    input  wire  i_req_2,
    input  wire  i_last_gnt,
    output logic o_valid,
    output logic o_gnt
);

    always_comb begin
        o_valid = i_req_1 | i_req_2;
        if (i_req_1 && i_req_2) begin
            o_gnt = (i_last_gnt == GNT_M1) ? GNT_M2 : GNT_M1;
        end else if (i_req_2) begin
            o_gnt = GNT_M2;
        end else begin
            o_gnt = GNT_M1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Registered two-master arbiter for one shared memory port with
//               access timeout. Define MEM_ARB_RR_EN for round-robin ties.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  wire          HCLK,
    input  wire          HRESET,
    mem_arbiter_if.slave bus
);

    localparam logic [TO_W-1:0] c_timeout = TO_W'(TIMEOUT);
    localparam bit              c_to_en   = (TIMEOUT != 0);

    state_t            r_state;
    logic              r_grant;
    logic              r_psel;
    logic              r_pwrite;
    logic [ADDR_W-1:0] r_paddr;
    logic [DATA_W-1:0] r_pwdata;
    logic [DATA_W-1:0] r_hrdata_1;
    logic [DATA_W-1:0] r_hrdata_2;
    logic              r_hready_1;
    logic              r_hready_2;
    logic              r_herr_1;
    logic              r_herr_2;
    logic [TO_W-1:0]   r_to_cnt;
    logic              w_last_gnt;
    logic              w_pick_valid;
    logic              w_pick_gnt;

`ifdef MEM_ARB_RR_EN
    logic r_last_gnt;

    // Resets to master 2 so that master 1 wins the very first tie.
    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) begin
            r_last_gnt <= GNT_M2;
        end else if (r_state == ST_IDLE && w_pick_valid) begin
            r_last_gnt <= w_pick_gnt;
        end
    end

    assign w_last_gnt = r_last_gnt;
`else
    assign w_last_gnt = GNT_M2;
`endif

    mem_arb_pick u_pick (
        .i_req_1    (bus.HTRANS_1),
        .i_req_2    (bus.HTRANS_2),
        .i_last_gnt (w_last_gnt),
        .o_valid    (w_pick_valid),
        .o_gnt      (w_pick_gnt)
    );

    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) begin
            r_state    <= ST_IDLE;
            r_grant    <= GNT_M1;
            r_psel     <= 1'b0;
            r_pwrite   <= 1'b0;
            r_paddr    <= '0;
            r_pwdata   <= '0;
            r_hrdata_1 <= '0;
            r_hrdata_2 <= '0;
            r_hready_1 <= 1'b0;
            r_hready_2 <= 1'b0;
            r_herr_1   <= 1'b0;
            r_herr_2   <= 1'b0;
            r_to_cnt   <= '0;
        end else begin
            r_hready_1 <= 1'b0;
            r_hready_2 <= 1'b0;
            r_herr_1   <= 1'b0;
            r_herr_2   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_valid) begin
                        r_grant  <= w_pick_gnt;
                        r_paddr  <= (w_pick_gnt == GNT_M2) ? bus.HADDR_2  : bus.HADDR_1;
                        r_pwrite <= (w_pick_gnt == GNT_M2) ? bus.HWRITE_2 : bus.HWRITE_1;
                        r_pwdata <= (w_pick_gnt == GNT_M2) ? bus.HWDATA_2 : bus.HWDATA_1;
                        r_psel   <= 1'b1;
                        r_to_cnt <= '0;
                        r_state  <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    // PREADY is checked first so a completion on the final cycle is not an error.
                    if (bus.PREADY) begin
                        if (!r_pwrite) begin
                            if (r_grant == GNT_M2) r_hrdata_2 <= bus.PRDATA;
                            else                   r_hrdata_1 <= bus.PRDATA;
                        end
                        if (r_grant == GNT_M2) r_hready_2 <= 1'b1;
                        else                   r_hready_1 <= 1'b1;
                        r_psel  <= 1'b0;
                        r_state <= ST_RESP;
                    end else if (c_to_en && r_to_cnt == c_timeout) begin
                        if (r_grant == GNT_M2) begin
                            r_hrdata_2 <= '0;
                            r_hready_2 <= 1'b1;
                            r_herr_2   <= 1'b1;
                        end else begin
                            r_hrdata_1 <= '0;
                            r_hready_1 <= 1'b1;
                            r_herr_1   <= 1'b1;
                        end
                        r_psel  <= 1'b0;
                        r_state <= ST_RESP;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.PSEL     = r_psel;
    assign bus.PADDR    = r_paddr;
    assign bus.PWRITE   = r_pwrite;
    assign bus.PWDATA   = r_pwdata;
    assign bus.HRDATA_1 = r_hrdata_1;
    assign bus.HRDATA_2 = r_hrdata_2;
    assign bus.HREADY_1 = r_hready_1;
    assign bus.HREADY_2 = r_hready_2;
    assign bus.HERR_1   = r_herr_1;
    assign bus.HERR_2   = r_herr_2;
    assign bus.grant    = r_grant;
    assign bus.stall    = (bus.HTRANS_1 & ~r_hready_1) | (bus.HTRANS_2 & ~r_hready_2);

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter (TIMEOUT=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int ADDR_W    = 64;
    localparam int DATA_W    = 64;
    localparam int TIMEOUT   = 4;
    localparam int TO_W      = 8;
    localparam int c_max_lat = TIMEOUT + 1;

    logic HCLK   = 1'b0;
    logic HRESET = 1'b0;
    int   checks = 0;
    int   errors = 0;

    mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) dut (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .bus    (bus)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        bit          m2;
        logic        wr;
        logic [63:0] addr;
        logic [63:0] wdata;
        int          k;          // cycles until PREADY, 0 = never
        logic [63:0] prdata;
        int          exp_lat;
        logic        exp_err;
        logic [63:0] exp_rdata;
    } vec_t;

    vec_t vecs[7];

    // Reference model state (transaction level)
    logic        a_act[2];
    logic        a_wr[2];
    logic [63:0] a_addr[2];
    logic [63:0] a_wdata[2];
    logic [63:0] m_rdata[2];
    logic        m_hready[2];
    logic        m_herr[2];
    bit          m_busy;
    int          m_start, m_k, m_avail, m_own;
    logic        m_last, m_grant, m_pwrite;
    logic [63:0] m_paddr, m_pwdata, cur_prdata;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_req(input bit m2, input logic act, input logic wr,
                             input logic [63:0] addr, input logic [63:0] wdata);
        if (m2) begin
            bus.HTRANS_2 = act; bus.HWRITE_2 = wr; bus.HADDR_2 = addr; bus.HWDATA_2 = wdata;
        end else begin
            bus.HTRANS_1 = act; bus.HWRITE_1 = wr; bus.HADDR_1 = addr; bus.HWDATA_1 = wdata;
        end
    endtask

    task automatic idle_inputs();
        drive_req(1'b0, 1'b0, 1'b0, '0, '0);
        drive_req(1'b1, 1'b0, 1'b0, '0, '0);
        bus.PREADY = 1'b0;
        bus.PRDATA = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_psel"},   bus.PSEL, 0);
        check({tag, "_paddr"},  bus.PADDR, 0);
        check({tag, "_pwrite"}, bus.PWRITE, 0);
        check({tag, "_pwdata"}, bus.PWDATA, 0);
        check({tag, "_grant"},  bus.grant, 0);
        check({tag, "_hrdy"},   {bus.HREADY_1, bus.HREADY_2, bus.HERR_1, bus.HERR_2}, 0);
        check({tag, "_hrd1"},   bus.HRDATA_1, 0);
        check({tag, "_hrd2"},   bus.HRDATA_2, 0);
    endtask

    initial begin
        logic [63:0] addrs[2];
        int          na, h1c, h2c, lat;
        bit          stall_ok, other_seen, prev_psel, seen;
        int          gseq[4];
        int          ng;

        vecs[0] = '{1'b1, 1'b0, 64'h1000, 64'h0,  2, 64'hDEADBEEF, 2, 1'b0, 64'hDEADBEEF};
        vecs[1] = '{1'b0, 1'b1, 64'h20,   64'h55, 1, 64'h1111,     1, 1'b0, 64'h0};
        vecs[2] = '{1'b0, 1'b0, 64'h20,   64'h0,  3, 64'h55,       3, 1'b0, 64'h55};
        vecs[3] = '{1'b0, 1'b1, 64'h28,   64'h99, 2, 64'h2222,     2, 1'b0, 64'h55};
        vecs[4] = '{1'b0, 1'b0, 64'h30,   64'h0,  0, 64'h4444,     5, 1'b1, 64'h0};
        vecs[5] = '{1'b1, 1'b0, 64'h48,   64'h0,  5, 64'hCAFE,     5, 1'b0, 64'hCAFE};
        vecs[6] = '{1'b1, 1'b1, 64'h50,   64'hAA, 6, 64'h3333,     5, 1'b1, 64'h0};

        // ---------------- reset values ----------------
        idle_inputs();
        repeat (2) @(negedge HCLK);
        check_reset_outputs("reset");
        check("reset_stall", bus.stall, 0);
        HRESET = 1'b1;

        // ---------------- simultaneous requests ----------------
        drive_req(1'b0, 1'b1, 1'b1, 64'h20, 64'h5A);
        drive_req(1'b1, 1'b1, 1'b0, 64'h40, 64'h0);
        bus.PREADY = 1'b1;
        bus.PRDATA = 64'h77;
        na = 0; h1c = -1; h2c = -1; stall_ok = 1; prev_psel = 0;
        addrs[0] = '1; addrs[1] = '1;
        for (int c = 0; c < 8; c++) begin
            @(negedge HCLK);
            if (bus.PSEL && !prev_psel && na < 2) begin addrs[na] = bus.PADDR; na++; end
            prev_psel = bus.PSEL;
            if (c <= 3 && !bus.stall) stall_ok = 0;
            if (bus.HREADY_1) begin h1c = c; drive_req(1'b0, 1'b0, 1'b0, '0, '0); end
            if (bus.HREADY_2) begin h2c = c; drive_req(1'b1, 1'b0, 1'b0, '0, '0); end
        end
        check("simul_first_addr", addrs[0], 64'h20);
        check("simul_second_addr", addrs[1], 64'h40);
        check("simul_hready1_cycle", h1c, 1);
        check("simul_hready2_cycle", h2c, 4);
        check("simul_stall_held", stall_ok, 1);
        check("simul_hrdata2", bus.HRDATA_2, 64'h77);
        idle_inputs();
        repeat (2) @(negedge HCLK);

        // ---------------- directed vectors ----------------
        for (int v = 0; v < 7; v++) begin
            @(negedge HCLK);
            drive_req(vecs[v].m2, 1'b1, vecs[v].wr, vecs[v].addr, vecs[v].wdata);
            bus.PRDATA = vecs[v].prdata;
            @(negedge HCLK);
            check($sformatf("v%0d_psel", v), bus.PSEL, 1);
            check($sformatf("v%0d_paddr", v), bus.PADDR, vecs[v].addr);
            check($sformatf("v%0d_pwrite", v), bus.PWRITE, vecs[v].wr);
            if (vecs[v].wr) check($sformatf("v%0d_pwdata", v), bus.PWDATA, vecs[v].wdata);
            check($sformatf("v%0d_grant", v), bus.grant, vecs[v].m2);
            check($sformatf("v%0d_stall", v), bus.stall, 1);
            lat = 0; other_seen = 0;
            for (int j = 1; j <= 10; j++) begin
                bus.PREADY = (vecs[v].k == j);
                @(negedge HCLK);
                if (vecs[v].m2 ? bus.HREADY_1 : bus.HREADY_2) other_seen = 1;
                if (vecs[v].m2 ? bus.HREADY_2 : bus.HREADY_1) begin lat = j; break; end
            end
            bus.PREADY = 1'b0;
            check($sformatf("v%0d_latency", v), lat, vecs[v].exp_lat);
            check($sformatf("v%0d_herr", v), vecs[v].m2 ? bus.HERR_2 : bus.HERR_1, vecs[v].exp_err);
            check($sformatf("v%0d_hrdata", v), vecs[v].m2 ? bus.HRDATA_2 : bus.HRDATA_1, vecs[v].exp_rdata);
            check($sformatf("v%0d_other_hready", v), other_seen, 0);
            check($sformatf("v%0d_psel_off", v), bus.PSEL, 0);
            drive_req(vecs[v].m2, 1'b0, 1'b0, '0, '0);
            @(negedge HCLK);
            check($sformatf("v%0d_pulse_one_cycle", v), {bus.HREADY_1, bus.HREADY_2, bus.HERR_1, bus.HERR_2}, 0);
        end

        // ---------------- reset mid-access ----------------
        @(negedge HCLK);
        drive_req(1'b0, 1'b1, 1'b0, 64'h60, '0);
        @(negedge HCLK);
        check("midrst_psel_before", bus.PSEL, 1);
        #2 HRESET = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge HCLK);
        idle_inputs();
        bus.PREADY = 1'b1;
        HRESET = 1'b1;
        seen = 0;
        repeat (4) begin
            @(negedge HCLK);
            if (bus.HREADY_1 || bus.HREADY_2 || bus.PSEL) seen = 1;
        end
        check("midrst_no_response", seen, 0);

        // ---------------- continuous contention ----------------
        drive_req(1'b0, 1'b1, 1'b0, 64'h100, '0);
        drive_req(1'b1, 1'b1, 1'b0, 64'h200, '0);
        ng = 0; prev_psel = 0;
        gseq = '{9, 9, 9, 9};
        for (int c = 0; c < 30 && ng < 4; c++) begin
            @(negedge HCLK);
            if (bus.PSEL && !prev_psel) begin gseq[ng] = int'(bus.grant); ng++; end
            prev_psel = bus.PSEL;
        end
        for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_RR_EN
            check($sformatf("contend_grant%0d", i), gseq[i], i % 2);
`else
            check($sformatf("contend_grant%0d", i), gseq[i], 0);
`endif
        end
        idle_inputs();

        // ---------------- randomized vs model ----------------
        @(negedge HCLK);
        HRESET = 1'b0;
        @(negedge HCLK);
        HRESET = 1'b1;
        for (int x = 0; x < 2; x++) begin
            a_act[x] = 0; a_wr[x] = 0; a_addr[x] = '0; a_wdata[x] = '0;
            m_rdata[x] = '0; m_hready[x] = 0; m_herr[x] = 0;
        end
        m_busy = 0; m_start = 0; m_k = 0; m_avail = 0; m_own = 0;
        m_last = 1'b1; m_grant = 1'b0; m_pwrite = 1'b0; m_paddr = '0; m_pwdata = '0;
        cur_prdata = '0;
        for (int e = 0; e < 900; e++) begin
            @(posedge HCLK);
            m_hready[0] = 0; m_hready[1] = 0; m_herr[0] = 0; m_herr[1] = 0;
            if (m_busy && e == m_start + ((m_k < c_max_lat) ? m_k : c_max_lat)) begin
                m_busy = 0;
                m_avail = e + 2;
                m_hready[m_own] = 1;
                if (m_k > c_max_lat) begin
                    m_herr[m_own] = 1;
                    m_rdata[m_own] = '0;
                end else if (!m_pwrite) begin
                    m_rdata[m_own] = cur_prdata;
                end
            end else if (!m_busy && e >= m_avail && (a_act[0] || a_act[1])) begin
                if (a_act[0] && a_act[1]) begin
`ifdef MEM_ARB_RR_EN
                    m_own = m_last ? 0 : 1;
`else
                    m_own = 0;
`endif
                end else begin
                    m_own = a_act[1] ? 1 : 0;
                end
                m_busy = 1; m_start = e; m_k = $urandom_range(1, 7);
                m_last = m_own[0]; m_grant = m_own[0];
                m_paddr = a_addr[m_own]; m_pwrite = a_wr[m_own]; m_pwdata = a_wdata[m_own];
            end
            @(negedge HCLK);
            check("rnd_psel", bus.PSEL, m_busy);
            check("rnd_grant", bus.grant, m_grant);
            check("rnd_paddr", bus.PADDR, m_paddr);
            check("rnd_pwrite", bus.PWRITE, m_pwrite);
            check("rnd_pwdata", bus.PWDATA, m_pwdata);
            check("rnd_hready1", bus.HREADY_1, m_hready[0]);
            check("rnd_hready2", bus.HREADY_2, m_hready[1]);
            check("rnd_herr1", bus.HERR_1, m_herr[0]);
            check("rnd_herr2", bus.HERR_2, m_herr[1]);
            check("rnd_hrdata1", bus.HRDATA_1, m_rdata[0]);
            check("rnd_hrdata2", bus.HRDATA_2, m_rdata[1]);
            check("rnd_stall", bus.stall, (a_act[0] & ~m_hready[0]) | (a_act[1] & ~m_hready[1]));
            for (int x = 0; x < 2; x++) begin
                if (m_hready[x]) a_act[x] = 0;
                if (!a_act[x] && $urandom_range(0, 2) == 0) begin
                    a_act[x] = 1;
                    a_wr[x] = 1'($urandom_range(0, 1));
                    a_addr[x] = {$urandom(), $urandom()};
                    a_wdata[x] = {$urandom(), $urandom()};
                end
                drive_req(x == 1, a_act[x], a_wr[x], a_addr[x], a_wdata[x]);
            end
            cur_prdata = {$urandom(), $urandom()};
            bus.PRDATA = cur_prdata;
            bus.PREADY = m_busy && (e + 1 == m_start + m_k);
        end
        idle_inputs();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
